// File: rtl/fetch.sv
// Instruction fetch: issues word reads from RESET_PC onward, queues PCs and presents {pc,inst} to decode.
// Latency: request one cycle after reset release; an instruction appears the cycle after its response.
// Backpressure: STALL holds the head; issue stops once outstanding + buffered would reach 2.
// Ports: CLK/RST_N clock and async active-low reset; STALL/FLUSH/NEW_PC from later stages;
//        MEM_REQ/MEM_ADDR/MEM_GNT request handshake; MEM_RVALID/MEM_RDATA in-order responses;
//        I_VALID/I_PC/I_INST registered instruction output (head of the 2-entry buffer).
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] NEW_PC,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_GNT,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA,
  output logic [31:0] I_PC,
  output logic [31:0] I_INST,
  output logic        I_VALID
);

  localparam logic [31:0] BOOT_PC = {RESET_PC[31:2], 2'b00};

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] fetch_pc;

  // PC queue: addresses of accepted requests awaiting a response
  logic [31:0] pq_pc [2];
  logic        pq_wp;
  logic        pq_rp;
  logic [1:0]  pq_cnt;
  logic [1:0]  pq_cnt_nxt;

  // Instruction buffer: {pc, inst} pairs waiting for decode
  logic [31:0] ib_pc   [2];
  logic [31:0] ib_inst [2];
  logic        ib_wp;
  logic        ib_rp;
  logic [1:0]  ib_cnt;

  // Responses still owed for requests issued before the last flush
  logic [1:0]  discard;

  logic        mem_acc;
  logic        rsp;
  logic        ib_push;
  logic        ib_pop;
  logic [2:0]  inflight;

  // A response with nothing outstanding belongs to a request abandoned by reset
  assign rsp        = MEM_RVALID && (pq_cnt != 2'd0);
  assign ib_pop     = I_VALID && !STALL;
  assign ib_push    = rsp && (discard == 2'd0) && !FLUSH;
  assign mem_acc    = MEM_REQ && MEM_GNT;
  assign pq_cnt_nxt = pq_cnt + {1'b0, mem_acc} - {1'b0, rsp};

  // Counting requests in flight together with buffered entries guarantees every
  // response has a buffer slot, so a response can never be lost.
  assign inflight = {1'b0, pq_cnt} + {1'b0, ib_cnt} - {2'b00, ib_pop};

  always_comb begin
    state_d = state_q;
    MEM_REQ = 1'b0;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     MEM_REQ = !FLUSH && (inflight < 3'd2);
      default: state_d = BOOT;
    endcase
  end

  assign MEM_ADDR = fetch_pc;
  assign I_VALID  = (ib_cnt != 2'd0);
  assign I_PC     = ib_pc[ib_rp];
  assign I_INST   = ib_inst[ib_rp];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= BOOT;
      fetch_pc <= BOOT_PC;
      pq_wp    <= 1'b0;
      pq_rp    <= 1'b0;
      pq_cnt   <= 2'd0;
      ib_wp    <= 1'b0;
      ib_rp    <= 1'b0;
      ib_cnt   <= 2'd0;
      discard  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        pq_pc[i]   <= 32'h0;
        ib_pc[i]   <= 32'h0;
        ib_inst[i] <= 32'h0;
      end
    end else begin
      state_q <= state_d;

      // Address advance wraps naturally at the top of the 32-bit space
      if (FLUSH) begin
        fetch_pc <= NEW_PC & 32'hFFFF_FFFC;
      end else if (mem_acc) begin
        fetch_pc <= fetch_pc + 32'd4;
      end

      // PC queue tracks every response, including the ones being discarded
      if (mem_acc) begin
        pq_pc[pq_wp] <= fetch_pc;
        pq_wp        <= ~pq_wp;
      end
      if (rsp) begin
        pq_rp <= ~pq_rp;
      end
      pq_cnt <= pq_cnt_nxt;

      // On flush everything still outstanding after this cycle becomes stale
      if (FLUSH) begin
        discard <= pq_cnt_nxt;
      end else if (rsp && (discard != 2'd0)) begin
        discard <= discard - 2'd1;
      end

      if (FLUSH) begin
        ib_wp  <= 1'b0;
        ib_rp  <= 1'b0;
        ib_cnt <= 2'd0;
      end else begin
        if (ib_push) begin
          ib_pc[ib_wp]   <= pq_pc[pq_rp];
          ib_inst[ib_wp] <= MEM_RDATA;
          ib_wp          <= ~ib_wp;
        end
        if (ib_pop) begin
          ib_rp <= ~ib_rp;
        end
        ib_cnt <= ib_cnt + {1'b0, ib_push} - {1'b0, ib_pop};
      end
    end
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset (bits [1:0] SHALL be treated as zero).
REQ-002 CLK  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 STALL  input  1  downstream (decode) cannot accept; hold current output.
REQ-005 FLUSH  input  1  redirect request from a later stage.
REQ-006 NEW_PC  input  32  redirect target, sampled when FLUSH=1.
REQ-007 MEM_REQ  output  1  instruction-memory read request valid.
REQ-008 MEM_ADDR  output  32  word-aligned read address.
REQ-009 MEM_GNT  input  1  memory accepts request this cycle.
REQ-010 MEM_RVALID  input  1  read data valid; responses return in request order, any latency >= 1 cycle.
REQ-011 MEM_RDATA  input  32  instruction word.
REQ-012 I_PC  output  32  PC of presented instruction.
REQ-013 I_INST  output  32  presented instruction.
REQ-014 I_VALID  output  1  I_PC/I_INST valid.

Function
REQ-015 Block SHALL hold a fetch PC, a 2-entry in-order PC queue for outstanding requests, a 2-entry instruction buffer {pc,inst}, and a discard counter (0..2).
REQ-016 State machine SHALL have states BOOT and RUN; BOOT lasts exactly one cycle after reset release, then RUN permanently; MEM_REQ=0 in BOOT.
REQ-017 In RUN, MEM_REQ SHALL be 1 when FLUSH=0 and (outstanding + buffered - pops this cycle) < 2, combinationally.
REQ-018 MEM_ADDR SHALL equal the fetch PC; request accepted when MEM_REQ=1 and MEM_GNT=1.
REQ-019 On acceptance, fetch PC SHALL advance by 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000, and the address SHALL be pushed on the PC queue.
REQ-020 MEM_ADDR SHALL stay stable while MEM_REQ=1 and MEM_GNT=0, except on FLUSH.
REQ-021 On MEM_RVALID=1 with discard counter > 0, response SHALL be dropped and counter decremented, PC queue popped.
REQ-022 On MEM_RVALID=1 with discard counter = 0, {PC-queue head, MEM_RDATA} SHALL be pushed into the instruction buffer.
REQ-023 I_VALID SHALL be 1 iff instruction buffer non-empty; I_PC/I_INST SHALL show its head (registered, no combinational path from MEM_RDATA).
REQ-024 Head SHALL be popped when I_VALID=1 and STALL=0; with STALL=1, I_PC/I_INST/I_VALID SHALL hold.
REQ-025 Push and pop in the same cycle SHALL be allowed, including when buffer is full.
REQ-026 Buffer overflow SHALL be impossible by REQ-017; no response is ever lost.
REQ-027 FLUSH=1 SHALL take priority over STALL and over any response: MEM_REQ=0 that cycle; buffer cleared; fetch PC <= {NEW_PC[31:2],2'b00}; discard counter <= outstanding requests after this cycle (responses arriving this cycle are dropped too).
REQ-028 I_VALID SHALL be 0 in the cycle after FLUSH; first redirected request SHALL issue that cycle if no discards block it.
REQ-029 FLUSH during BOOT SHALL update the fetch PC only.

Reset
REQ-030 While RST_N=0: state BOOT, fetch PC = RESET_PC with [1:0]=0, queues empty, discard counter 0, MEM_REQ=0, MEM_ADDR=RESET_PC, I_VALID=0, I_PC=0, I_INST=0.
REQ-031 Reset assertion mid-transaction SHALL abandon all outstanding requests; responses arriving after release, with none outstanding, SHALL be ignored.

Verification
REQ-032 Reset, MEM_GNT=1, 1-cycle latency, STALL=0 -> MEM_ADDR 0,4,8,... on consecutive cycles; I_PC 0,4,8 with I_INST matching memory, I_VALID continuous.
REQ-033 STALL=1 for 5 cycles while streaming -> outputs frozen, MEM_REQ drops after 2 buffered; after release no instruction skipped or duplicated.
REQ-034 FLUSH with NEW_PC=32'h0000_0103 while 2 requests outstanding -> next MEM_ADDR 32'h0000_0100, both stale responses dropped, first I_PC after flush = 32'h0000_0100.
REQ-035 MEM_GNT held 0 for 3 cycles -> MEM_ADDR constant, PC not advanced; random GNT/RVALID latency 1-4 -> in-order, gap-free PC stream.
REQ-036 RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 RST_N pulsed low with requests outstanding -> all outputs at reset values immediately; fetch restarts at RESET_PC.
